// File: rtl/mux_sel_sequencer.sv
// -----------------------------------------------------------------------------
// mux_sel_sequencer
//
// Control stage that sits in front of the source-select 2:1 mux and drives its
// two select qualifiers. The mux passes source b only while sel_b1 & sel_b2 is
// high, otherwise source a.
//
// The block does three things:
//   * debounces the raw switch request (req_b) into a filtered level (req_f),
//   * waits for the downstream consumer to be idle before switching to b,
//   * keeps b selected for a minimum dwell, then releases the selects in stages:
//     sel_b2 drops first and sel_b1 follows HOLD cycles later.
//
// Parameters
//   STABLE    : consecutive samples req_b must hold a new level before req_f
//               follows it (>= 1)
//   MIN_DWELL : minimum number of cycles spent in SEL_B (>= 1)
//   HOLD      : number of cycles spent in DRAIN, with sel_b1 still high (>= 1)
//
// Ports
//   clk        in   single clock, all state updates on its rising edge
//   resetn     in   asynchronous, active-low reset
//   req_b      in   raw request to select source b (level, may glitch)
//   busy       in   consumer busy; blocks a switch into b while high
//   sel_b1     out  first mux select qualifier (registered)
//   sel_b2     out  second mux select qualifier (registered)
//   state      out  FSM state: IDLE_A=0, ARM=1, SEL_B=2, DRAIN=3
//   switch_cnt out  number of completed entries into SEL_B, modulo 256
// -----------------------------------------------------------------------------
module mux_sel_sequencer #(
  parameter int STABLE    = 3,
  parameter int MIN_DWELL = 4,
  parameter int HOLD      = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req_b,
  input  logic       busy,
  output logic       sel_b1,
  output logic       sel_b2,
  output logic [1:0] state,
  output logic [7:0] switch_cnt
);

  // Each counter is one bit wider than needed to hold its load value.
  localparam int CNT_W   = $clog2(STABLE) + 1;
  localparam int DWELL_W = $clog2(MIN_DWELL) + 1;
  localparam int HOLD_W  = $clog2(HOLD) + 1;

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(STABLE - 1);
  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(MIN_DWELL - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD - 1);

  typedef enum logic [1:0] {
    IDLE_A = 2'd0,
    ARM    = 2'd1,
    SEL_B  = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic               req_f_q,      req_f_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;
  state_t             state_q,      state_d;
  logic [DWELL_W-1:0] dwell_q,      dwell_d;
  logic [HOLD_W-1:0]  hold_q,       hold_d;
  logic [7:0]         switch_cnt_q, switch_cnt_d;
  logic               sel_b1_q,     sel_b1_d;
  logic               sel_b2_q,     sel_b2_d;

  // ---------------------------------------------------------------------------
  // Debounce filter
  // cnt counts consecutive samples where req_b disagrees with req_f. Any sample
  // that agrees again throws the partial count away, so a glitch shorter than
  // STABLE samples never reaches the FSM.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_f_d = req_f_q;
    cnt_d   = cnt_q;
    if (req_b == req_f_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      req_f_d = req_b;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // The FSM looks at req_f_q, i.e. the filtered level before this edge's filter
  // update, which adds one cycle between req_f changing and the FSM reacting.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    dwell_d      = dwell_q;
    hold_d       = hold_q;
    switch_cnt_d = switch_cnt_q;

    case (state_q)
      IDLE_A: begin
        if (req_f_q) begin
          state_d = ARM;
        end
      end

      ARM: begin
        // Abort wins over a simultaneous drop of busy.
        if (!req_f_q) begin
          state_d = IDLE_A;
        end else if (!busy) begin
          state_d      = SEL_B;
          dwell_d      = DWELL_LOAD;
          switch_cnt_d = switch_cnt_q + 8'd1;
        end
      end

      SEL_B: begin
        // busy is deliberately ignored here: once on b we only leave on a
        // filtered request drop after the dwell has expired.
        if ((dwell_q == '0) && !req_f_q) begin
          state_d = DRAIN;
          hold_d  = HOLD_LOAD;
        end else if (dwell_q != '0) begin
          dwell_d = dwell_q - DWELL_W'(1);
        end
      end

      DRAIN: begin
        // Fixed-length release; a returning request only re-arms from IDLE_A.
        if (hold_q == '0) begin
          state_d = IDLE_A;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end

      default: begin
        state_d = IDLE_A;
      end
    endcase
  end

  // Selects are decoded from the next state so that, once registered, they
  // line up exactly with the registered state (Moore, no input-to-output path).
  always_comb begin
    sel_b1_d = (state_d != IDLE_A);
    sel_b2_d = (state_d == SEL_B);
  end

  // ---------------------------------------------------------------------------
  // All flops. Reset is asynchronous so the mux falls back to source a at once,
  // even mid-SEL_B and without a running clock.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_f_q      <= 1'b0;
      cnt_q        <= '0;
      state_q      <= IDLE_A;
      dwell_q      <= '0;
      hold_q       <= '0;
      switch_cnt_q <= 8'd0;
      sel_b1_q     <= 1'b0;
      sel_b2_q     <= 1'b0;
    end else begin
      req_f_q      <= req_f_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      dwell_q      <= dwell_d;
      hold_q       <= hold_d;
      switch_cnt_q <= switch_cnt_d;
      sel_b1_q     <= sel_b1_d;
      sel_b2_q     <= sel_b2_d;
    end
  end

  assign sel_b1     = sel_b1_q;
  assign sel_b2     = sel_b2_q;
  assign state      = state_q;
  assign switch_cnt = switch_cnt_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mux_sel_sequencer
//
// Self-checking bench for mux_sel_sequencer with default parameters.
// A table of per-cycle vectors covers the clean switch / dwell / drain path,
// hand-written sequences cover glitch rejection, busy stall, abort, async
// reset and switch_cnt wrap, and a random run is compared cycle by cycle with
// a behavioural model that reasons in "cycles since entering a state".
// -----------------------------------------------------------------------------
module tb_mux_sel_sequencer;

  localparam int STABLE    = 3;
  localparam int MIN_DWELL = 4;
  localparam int HOLD      = 2;

  logic       clk;
  logic       resetn;
  logic       req_b;
  logic       busy;
  logic       sel_b1;
  logic       sel_b2;
  logic [1:0] state;
  logic [7:0] switch_cnt;

  int compared;
  int mismatched;

  mux_sel_sequencer #(
    .STABLE    (STABLE),
    .MIN_DWELL (MIN_DWELL),
    .HOLD      (HOLD)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_b      (req_b),
    .busy       (busy),
    .sel_b1     (sel_b1),
    .sel_b2     (sel_b2),
    .state      (state),
    .switch_cnt (switch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: filtered level plus "cycles since entry" per state.
  // ---------------------------------------------------------------------------
  bit m_req_f;
  int m_run;
  int m_state;
  int m_k;
  int m_swc;
  bit use_model;

  task automatic model_reset();
    m_req_f = 1'b0;
    m_run   = 0;
    m_state = 0;
    m_k     = 0;
    m_swc   = 0;
  endtask

  task automatic model_step(input bit rb, input bit bz);
    bit old_f;
    old_f = m_req_f;
    if (rb != m_req_f) begin
      m_run++;
      if (m_run == STABLE) begin
        m_req_f = rb;
        m_run   = 0;
      end
    end else begin
      m_run = 0;
    end
    case (m_state)
      0: if (old_f) begin m_state = 1; m_k = 0; end
      1: begin
        if (!old_f) m_state = 0;
        else if (!bz) begin
          m_state = 2;
          m_k     = 0;
          m_swc   = (m_swc + 1) % 256;
        end
      end
      2: begin
        if (m_k >= MIN_DWELL - 1 && !old_f) begin m_state = 3; m_k = 0; end
        else m_k++;
      end
      default: begin
        if (m_k >= HOLD - 1) m_state = 0;
        else m_k++;
      end
    endcase
  endtask

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    if (use_model) model_step(req_b, busy);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req_b  = 1'b0;
    busy   = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // Drive one A->B transition; returns once SEL_B is visible.
  task automatic enter_b(input string tag);
    int n;
    req_b = 1'b1;
    busy  = 1'b0;
    n = 0;
    while (state != 2'd2 && n < 20) begin
      tick();
      n++;
    end
    if (state != 2'd2) begin
      mismatched++;
      compared++;
      $display("FAIL %s_enter_timeout: state %0d, expected 2", tag, state);
    end
  endtask

  // Drop the request and wait for IDLE_A.
  task automatic leave_b(input string tag);
    int n;
    req_b = 1'b0;
    n = 0;
    while (state != 2'd0 && n < 30) begin
      tick();
      n++;
    end
    if (state != 2'd0) begin
      mismatched++;
      compared++;
      $display("FAIL %s_leave_timeout: state %0d, expected 0", tag, state);
    end
  endtask

  typedef struct {
    logic       rb;
    logic       bz;
    logic [1:0] st;
    logic       s1;
    logic       s2;
    logic [7:0] swc;
  } vec_t;

  vec_t vecs[12];

  initial begin
    compared   = 0;
    mismatched = 0;
    use_model  = 1'b0;
    resetn     = 1'b0;
    req_b      = 1'b0;
    busy       = 1'b0;

    // Clean switch, minimum dwell and drain. Row n: inputs before edge n+1,
    // expected outputs after it. req_b falls right after SEL_B is entered.
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 8'd0};
    vecs[4]  = '{1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 8'd1};
    vecs[5]  = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 8'd1};
    vecs[6]  = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 8'd1};
    vecs[7]  = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 8'd1};
    vecs[8]  = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 8'd1};
    vecs[9]  = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 8'd1};
    vecs[10] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd1};
    vecs[11] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd1};

    // Reset state
    do_reset();
    chk("reset_state", state, 0);
    chk("reset_sel_b1", sel_b1, 0);
    chk("reset_sel_b2", sel_b2, 0);
    chk("reset_switch_cnt", switch_cnt, 0);

    // Table-driven clean switch / dwell / drain
    for (int i = 0; i < 12; i++) begin
      req_b = vecs[i].rb;
      busy  = vecs[i].bz;
      tick();
      $display("vec %0d: req_b=%0d busy=%0d -> state=%0d sel_b1=%0d sel_b2=%0d cnt=%0d",
               i, vecs[i].rb, vecs[i].bz, state, sel_b1, sel_b2, switch_cnt);
      chk($sformatf("vec%0d_state", i), state, vecs[i].st);
      chk($sformatf("vec%0d_sel_b1", i), sel_b1, vecs[i].s1);
      chk($sformatf("vec%0d_sel_b2", i), sel_b2, vecs[i].s2);
      chk($sformatf("vec%0d_switch_cnt", i), switch_cnt, vecs[i].swc);
    end

    // Glitch rejection: 2 samples high, then low
    do_reset();
    req_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) req_b = 1'b0;
      tick();
      chk($sformatf("glitch%0d_state", i), state, 0);
      chk($sformatf("glitch%0d_sel", i), {sel_b1, sel_b2}, 0);
    end
    $display("glitch: state=%0d sel_b1=%0d sel_b2=%0d", state, sel_b1, sel_b2);

    // Busy stall in ARM for 6 cycles, then release
    do_reset();
    req_b = 1'b1;
    busy  = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("stall_arm_state", state, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("stall%0d_state", i), state, 1);
      chk($sformatf("stall%0d_sel", i), {sel_b1, sel_b2}, 2'b10);
    end
    busy = 1'b0;
    tick();
    chk("stall_release_state", state, 2);
    chk("stall_release_cnt", switch_cnt, 1);
    $display("busy stall: state=%0d cnt=%0d", state, switch_cnt);

    // Abort from ARM: req_b low for 3 edges, FSM sees it one edge later
    do_reset();
    req_b = 1'b1;
    busy  = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("abort_arm_state", state, 1);
    req_b = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("abort_still_arm", state, 1);
    tick();
    chk("abort_state", state, 0);
    chk("abort_sel", {sel_b1, sel_b2}, 0);
    chk("abort_cnt", switch_cnt, 0);
    $display("abort: state=%0d cnt=%0d", state, switch_cnt);

    // Async reset mid-SEL_B with switch_cnt = 5
    do_reset();
    for (int i = 0; i < 4; i++) begin
      enter_b("areset");
      leave_b("areset");
    end
    enter_b("areset");
    chk("areset_pre_cnt", switch_cnt, 5);
    chk("areset_pre_state", state, 2);
    #2;
    resetn = 1'b0;
    #1;
    chk("areset_state", state, 0);
    chk("areset_sel_b1", sel_b1, 0);
    chk("areset_sel_b2", sel_b2, 0);
    chk("areset_cnt", switch_cnt, 0);
    $display("async reset: state=%0d sel=%0d%0d cnt=%0d", state, sel_b1, sel_b2, switch_cnt);
    @(posedge clk);
    #1;
    chk("areset_hold_state", state, 0);
    resetn = 1'b1;
    req_b  = 1'b0;

    // switch_cnt wrap over 256 entries
    do_reset();
    for (int i = 0; i < 256; i++) begin
      enter_b("wrap");
      chk($sformatf("wrap%0d_cnt", i), switch_cnt, (i + 1) % 256);
      leave_b("wrap");
    end
    $display("wrap: cnt=%0d after 256 entries", switch_cnt);

    // Randomized run against the reference model
    do_reset();
    use_model = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) req_b = ~req_b;
      busy = ($urandom_range(0, 2) == 0);
      tick();
      chk("rnd_state", state, m_state);
      chk("rnd_sel_b1", sel_b1, (m_state != 0) ? 1 : 0);
      chk("rnd_sel_b2", sel_b2, (m_state == 2) ? 1 : 0);
      chk("rnd_switch_cnt", switch_cnt, m_swc);
    end
    use_model = 1'b0;
    $display("random: final state=%0d cnt=%0d model cnt=%0d", state, switch_cnt, m_swc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mux_sel_sequencer.md
# mux_sel_sequencer

Control stage that sits directly upstream of the source-select 2:1 mux and drives that mux's `sel_b1` and `sel_b2` inputs. The mux passes `b` only when `sel_b1 & sel_b2`, otherwise `a`. This block debounces a raw switch request, waits for the downstream consumer to be idle, and enforces a minimum dwell on source `b`. It also enforces a staged release, so the mux never changes source on a glitch or while the consumer is busy.

## Interface
Parameters:
- `STABLE`, 3: consecutive sampled edges `req_b` must hold a new level before the filtered request changes (≥1).
- `MIN_DWELL`, 4: minimum cycles spent in SEL_B (≥1).
- `HOLD`, 2: cycles spent in DRAIN with `sel_b1` held after `sel_b2` drops (≥1).

Ports:
- `clk` input 1: single clock, all state updates on posedge.
- `resetn` input 1: asynchronous, active-low reset.
- `req_b` input 1: raw request to select source `b` (level, may glitch).
- `busy` input 1: consumer busy; a switch into `b` is forbidden while high.
- `sel_b1` output 1: first mux select qualifier (registered).
- `sel_b2` output 1: second mux select qualifier (registered).
- `state` output 2: FSM state, encoded IDLE_A=0, ARM=1, SEL_B=2, DRAIN=3.
- `switch_cnt` output 8: count of completed entries into SEL_B; wraps 255→0.

## Operation
- Debounce filter: internal `req_f` (reset 0) and counter `cnt` (reset 0), updated each posedge.
  - `req_b == req_f`: `cnt <= 0`.
  - Otherwise, if `cnt == STABLE-1`: `req_f <= req_b`, `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
  - Any sampled return to `req_f` level restarts the count.
- FSM outputs are Moore, decoded from registered state (no combinational input-to-output path):
  - IDLE_A: `sel_b1=0`, `sel_b2=0`. Goes to ARM when `req_f==1`.
  - ARM: `sel_b1=1`, `sel_b2=0`.
    - `req_f==0` → IDLE_A (abort; takes priority).
    - Else `busy==0` → SEL_B.
    - Else stay in ARM.
  - SEL_B: `sel_b1=1`, `sel_b2=1`.
    - On entry, `dwell` is loaded with MIN_DWELL-1 and `switch_cnt` increments.
    - Each cycle in SEL_B, `dwell` decrements, saturating at 0.
    - Goes to DRAIN when `dwell==0 && req_f==0`.
    - `busy` is ignored in this state.
  - DRAIN: `sel_b1=1`, `sel_b2=0`.
    - On entry, `hold` is loaded with HOLD-1; it decrements each cycle.
    - Goes to IDLE_A when `hold==0`.
    - `req_f` is ignored. If `req_f` is still 1 on reaching IDLE_A, the block re-arms on the next edge.
- The FSM sees `req_f` as registered (the value before the current edge's filter update).
- Counter widths are `$clog2` of the parameter value plus 1 bit. No counter ever exceeds its load value.
- `switch_cnt` is modulo 256.

## Timing
- Reset (`resetn` low): immediately and without a clock, the block forces the following, and holds them while `resetn` is low:
  - `state`=IDLE_A, `sel_b1=0`, `sel_b2=0`, `switch_cnt=0`;
  - `req_f=0`, `cnt=0`, `dwell=0`, `hold=0`.
  - Reset mid-SEL_B drops both selects at once. The mux therefore returns to `a`.
- Release of reset is synchronous to the design. The first state change can occur at the first posedge after deassertion.
- Entry latency: `req_b` high at posedges 1..STABLE with `busy=0` gives:
  - `req_f=1` after edge STABLE;
  - ARM (`sel_b1=1`) after edge STABLE+1;
  - SEL_B (`sel_b2=1`) after edge STABLE+2.
- `busy` high in ARM stalls entry one cycle per cycle busy is high. SEL_B follows the first edge that samples `busy=0`.
- Exit:
  - SEL_B lasts at least MIN_DWELL cycles.
  - After `req_f` falls with `dwell==0`, DRAIN follows on the next edge.
  - DRAIN lasts exactly HOLD cycles, then IDLE_A.
- Ordering guarantee: `sel_b2` rises only when `sel_b1` is already high, and falls at least HOLD cycles before `sel_b1` falls. `sel_b1 & sel_b2` is high only in SEL_B.
- Simultaneous events:
  - `req_f` falling while `busy` changes in ARM resolves as abort to IDLE_A.
  - `req_f` re-rising during DRAIN does not shorten DRAIN.

## Test plan
All scenarios use the default parameters.
- Glitch rejection: `req_b` high for 2 posedges, then low. Required: `req_f` stays 0, `sel_b1`/`sel_b2` stay 0, `state`=0 throughout.
- Clean switch: `req_b` held high from edge 1, `busy=0`. Required:
  - `req_f=1` after edge 3;
  - `sel_b1=1`, `state`=1 after edge 4;
  - `sel_b2=1`, `state`=2 after edge 5;
  - `switch_cnt=1`.
- Busy stall and abort:
  - `busy=1` for 6 cycles in ARM: remain `state`=1, `sel_b1=1`, `sel_b2=0`. `busy` dropping gives `state`=2 on the next edge.
  - Separately, `req_b` low for 3 edges while in ARM: return to `state`=0, `switch_cnt` unchanged.
- Minimum dwell and drain: `req_b` driven low on the edge SEL_B is entered. Required:
  - `sel_b2` high for exactly 4 cycles;
  - `state`=3 for 2 cycles with `sel_b1=1`, `sel_b2=0`;
  - then `state`=0 with both selects 0.
- Async reset mid-operation: assert `resetn=0` between clock edges while in SEL_B with `switch_cnt=5`. Required: `sel_b1=0`, `sel_b2=0`, `state`=0, `switch_cnt=0` before the next posedge.
- Counter wrap: 256 complete A→B→A sequences. Required: `switch_cnt` reads 255 after the 255th entry and 0 after the 256th.
